rv_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the decoder. Generates the PC and issues

---
 rtl/rv_pkg.sv | 19 +
 rtl/rv_fetch_fifo.sv | 72 +++++++
 rtl/rv_fetch.sv | 141 ++++++++++++++
 tb/tb_rv_fetch.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rv_pkg                                                  |
// | Brief  : Shared RISC-V front-end types and constants.            |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
package rv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/rv_fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rv_fetch_fifo                                           |
// | Brief  : Synchronous fetch buffer with flush; read data is the   |
// |          registered head entry.                                  |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module rv_fetch_fifo #(
    parameter int               DEPTH      = 2,
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Push into a full buffer is only legal alongside a pop.
    assign do_push = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_DATA;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_q + CW'(do_push) - CW'(do_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rv_fetch                                                |
// | Brief  : PC generation, credit-limited imem requests, redirect   |
// |          squash and decoder-facing fetch buffer.                 |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module rv_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          gnt_fire;
    logic          rsp_fire;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [63:0]   fifo_rdata;

    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_o  = (state_q == ST_RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr_o = pc_q;
    assign gnt_fire    = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire    = imem_rvalid_i && (outstanding_q != '0);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        fifo_push     = 1'b0;
        outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);

        if (gnt_fire) begin
            pc_d = pc_q + 32'd4;
        end

        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (rsp_fire && discard_q == '0) begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = rsp_pc_q + 32'd4;
                end
            end
            ST_DRAIN: begin
                if (rsp_fire && discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end
                if (discard_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // Everything still in flight, including a same-cycle grant, belongs to the old path.
        if (redirect_i) begin
            pc_d      = {redirect_pc_i[31:2], 2'b00};
            rsp_pc_d  = {redirect_pc_i[31:2], 2'b00};
            discard_d = outstanding_d;
            fifo_push = 1'b0;
            state_d   = (outstanding_d == '0) ? ST_RUN : ST_DRAIN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign fifo_pop = instr_valid_o && instr_ready_i;

    rv_fetch_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .WIDTH      (64),
        .RESET_DATA ({RESET_PC, RV_NOP})
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  ({rsp_pc_q, imem_rdata_i}),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_pc_o    = fifo_rdata[63:32];
    assign instr_o       = fifo_rdata[31:0];

    a_rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (outstanding_q != '0)
    );

    a_fifo_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni) fifo_push |-> (!fifo_full || fifo_pop)
    );

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_rv_fetch                                             |
// | Brief  : Self-checking bench for rv_fetch with memory model and  |
// |          in-order instruction scoreboard.                        |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rv_fetch;
    import rv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    rv_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_deliv  = 0;
    logic [31:0] pending[$];
    logic [31:0] gnt_log[$];
    logic [31:0] exp_pc   = RESET_PC;
    logic [31:0] exp_req  = RESET_PC;
    logic [31:0] last_deliv_pc;

    // Memory contents: a bijective scramble of the word address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F};
    endfunction

    task automatic set_mem(input int gnt_pct, input int rv_pct);
        imem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
        if (pending.size() != 0 && $urandom_range(0, 99) < rv_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memfn(pending[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
    endtask

    // One clock: observe handshakes before the edge, update model, check after.
    task automatic tick();
        logic redir_now;
        redir_now = 1'b0;
        #1;
        if (rst_ni) begin
            if (imem_req_o) begin
                n_checks++;
                if (imem_addr_o !== exp_req) begin
                    n_fail++;
                    $display("FAIL req_addr: got %h expected %h", imem_addr_o, exp_req);
                end
            end
            if (imem_req_o && imem_gnt_i) begin
                pending.push_back(imem_addr_o);
                gnt_log.push_back(imem_addr_o);
                exp_req = exp_req + 32'd4;
            end
            if (imem_rvalid_i) begin
                void'(pending.pop_front());
            end
            if (instr_valid_o && instr_ready_i) begin
                n_checks++;
                if (instr_pc_o !== exp_pc || instr_o !== memfn(exp_pc)) begin
                    n_fail++;
                    $display("FAIL deliver: got pc %h instr %h expected pc %h instr %h",
                             instr_pc_o, instr_o, exp_pc, memfn(exp_pc));
                end
                last_deliv_pc = instr_pc_o;
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (redirect_i) begin
                exp_pc    = {redirect_pc_i[31:2], 2'b00};
                exp_req   = {redirect_pc_i[31:2], 2'b00};
                redir_now = 1'b1;
            end
        end else begin
            pending.delete();
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
        end
        @(posedge clk_i);
        #1;
        if (redir_now) begin
            n_checks++;
            if (instr_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_after_redirect: got %b expected 0", instr_valid_o);
            end
        end
        n_checks++;
        if (pending.size() > DEPTH) begin
            n_fail++;
            $display("FAIL outstanding_bound: got %0d expected <= %0d", pending.size(), DEPTH);
        end
    endtask

    task automatic quiesce();
        int c;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b0;
        c = 0;
        while ((pending.size() != 0 || instr_valid_o) && c < 50) begin
            set_mem(0, 100);
            tick();
            c++;
        end
        n_checks++;
        if (c >= 50) begin
            n_fail++;
            $display("FAIL quiesce_timeout: got busy after %0d cycles expected idle", c);
        end
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_1234;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b1;
        tick();
        tick();
        redirect_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req_o);
        end
        n_checks++;
        if (instr_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o);
        end
        n_checks++;
        if (instr_o !== RV_NOP) begin
            n_fail++; $display("FAIL reset_instr: got %h expected %h", instr_o, RV_NOP);
        end
        n_checks++;
        if (instr_pc_o !== RESET_PC) begin
            n_fail++; $display("FAIL reset_pc: got %h expected %h", instr_pc_o, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        int first;
        int d0;
        rst_ni = 1'b1;
        first  = -1;
        for (int c = 1; c <= 10 && first < 0; c++) begin
            set_mem(100, 100);
            tick();
            if (instr_valid_o) first = c;
        end
        n_checks++;
        if (first != 3) begin
            n_fail++; $display("FAIL first_valid_latency: got %0d expected 3", first);
        end
        n_checks++;
        if (instr_pc_o !== RESET_PC) begin
            n_fail++; $display("FAIL first_pc: got %h expected %h", instr_pc_o, RESET_PC);
        end
        d0 = n_deliv;
        for (int c = 0; c < 20; c++) begin
            set_mem(100, 100);
            tick();
        end
        n_checks++;
        if (n_deliv - d0 < 10) begin
            n_fail++; $display("FAIL seq_throughput: got %0d expected >= 10", n_deliv - d0);
        end
    endtask

    task automatic test_stall();
        int g0;
        int d0;
        quiesce();
        instr_ready_i = 1'b0;
        g0 = gnt_log.size();
        for (int c = 0; c < 10; c++) begin
            set_mem(100, 100);
            tick();
            if (c >= 5) begin
                n_checks++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc || instr_o !== memfn(exp_pc)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v%b pc %h instr %h expected v1 pc %h instr %h",
                             instr_valid_o, instr_pc_o, instr_o, exp_pc, memfn(exp_pc));
                end
            end
        end
        n_checks++;
        if (gnt_log.size() - g0 != DEPTH) begin
            n_fail++; $display("FAIL stall_grants: got %0d expected %0d", gnt_log.size() - g0, DEPTH);
        end
        n_checks++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_req_drop: got %b expected 0", imem_req_o);
        end
        instr_ready_i = 1'b1;
        d0 = n_deliv;
        for (int c = 0; c < 6; c++) begin
            set_mem(0, 100);
            tick();
        end
        n_checks++;
        if (n_deliv - d0 != DEPTH) begin
            n_fail++; $display("FAIL stall_release: got %0d expected %0d", n_deliv - d0, DEPTH);
        end
    endtask

    task automatic test_redirect();
        int d0;
        quiesce();
        for (int c = 0; c < 3; c++) begin
            set_mem(100, 0);
            tick();
        end
        n_checks++;
        if (pending.size() != 2) begin
            n_fail++; $display("FAIL redir_setup: got %0d outstanding expected 2", pending.size());
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        tick();
        redirect_i = 1'b0;
        n_checks++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL drain_no_req: got %b expected 0", imem_req_o);
        end
        gnt_log.delete();
        d0 = n_deliv;
        for (int c = 0; c < 30 && n_deliv == d0; c++) begin
            set_mem(100, 100);
            tick();
        end
        n_checks++;
        if (n_deliv == d0 || last_deliv_pc !== 32'h0000_0100) begin
            n_fail++; $display("FAIL redir_first_pc: got %h expected 00000100", last_deliv_pc);
        end
        n_checks++;
        if (gnt_log.size() == 0 || gnt_log[0] !== 32'h0000_0100) begin
            n_fail++; $display("FAIL redir_first_req: got %0d grants expected first at 00000100", gnt_log.size());
        end
    endtask

    task automatic test_redirect_race();
        bit found;
        int d0;
        found = 1'b0;
        instr_ready_i = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            set_mem(100, 100);
            if (imem_req_o && pending.size() != 0) begin
                found         = 1'b1;
                imem_gnt_i    = 1'b1;
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = memfn(pending[0]);
                redirect_i    = 1'b1;
                redirect_pc_i = 32'h0000_0200;
            end
            tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL race_setup: got no gnt+rvalid cycle expected one");
        end
        n_checks++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL race_drain: got req %b expected 0", imem_req_o);
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0301;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        tick();
        redirect_i = 1'b0;
        gnt_log.delete();
        d0 = n_deliv;
        for (int c = 0; c < 30 && n_deliv == d0; c++) begin
            set_mem(100, 100);
            tick();
        end
        n_checks++;
        if (n_deliv == d0 || last_deliv_pc !== 32'h0000_0300) begin
            n_fail++; $display("FAIL race_first_pc: got %h expected 00000300", last_deliv_pc);
        end
    endtask

    task automatic test_wrap();
        quiesce();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        tick();
        redirect_i = 1'b0;
        gnt_log.delete();
        for (int c = 0; c < 20 && gnt_log.size() < 3; c++) begin
            set_mem(100, 100);
            tick();
        end
        n_checks++;
        if (gnt_log.size() < 3 || gnt_log[0] !== 32'hFFFF_FFF8 || gnt_log[1] !== 32'hFFFF_FFFC
            || gnt_log[2] !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_addrs: got %0d grants expected FFFFFFF8,FFFFFFFC,00000000", gnt_log.size());
        end
        for (int c = 0; c < 6; c++) begin
            set_mem(100, 100);
            tick();
        end
    endtask

    task automatic test_random();
        int d0;
        d0 = n_deliv;
        for (int c = 0; c < 4000; c++) begin
            set_mem(60, 60);
            instr_ready_i = ($urandom_range(0, 99) < 70);
            redirect_i    = ($urandom_range(0, 99) < 2);
            redirect_pc_i = $urandom;
            if (c == 2000) begin
                rst_ni = 1'b0;
                tick();
                rst_ni = 1'b1;
                n_checks++;
                if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== RV_NOP
                    || instr_pc_o !== RESET_PC) begin
                    n_fail++;
                    $display("FAIL midrun_reset: got req %b valid %b instr %h pc %h expected 0 0 %h %h",
                             imem_req_o, instr_valid_o, instr_o, instr_pc_o, RV_NOP, RESET_PC);
                end
            end else begin
                tick();
            end
        end
        redirect_i = 1'b0;
        n_checks++;
        if (n_deliv - d0 < 200) begin
            n_fail++; $display("FAIL random_progress: got %0d deliveries expected >= 200", n_deliv - d0);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_race();
        test_wrap();
        test_random();
        quiesce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
